// File: rtl/tomasulo_pkg.sv
// Shared Tomasulo definitions: tag/data widths, adder op codes, the reserved
// "no producer" tag and the message broadcast on the common data bus.
package tomasulo_pkg;

  localparam int TAG_W  = 8;
  localparam int DATA_W = 8;

  localparam logic [3:0] OP_ADD = 4'b0000;
  localparam logic [3:0] OP_SUB = 4'b0001;

  // Tag 0 marks a register whose value is already available; never a real producer.
  localparam logic [TAG_W-1:0] TAG_NONE = '0;

  typedef struct packed {
    logic [TAG_W-1:0]  tag;
    logic [DATA_W-1:0] value;
    logic              ovf;
  } cdb_msg_t;

endpackage

// File: rtl/result_fifo.sv
// Result buffer between the execute pipeline and the CDB: an in-order FIFO of
// finished results waiting for a bus grant.
// Ports:
//   clk, rst_n    clock, asynchronous active-low reset
//   push_i        write push_msg_i at the tail (caller guarantees space)
//   push_msg_i    finished result
//   pop_i         drop the head entry (ignored when empty)
//   head_o        oldest entry, valid while count_o != 0
//   count_o       number of occupied entries
module result_fifo
  import tomasulo_pkg::*;
#(
  parameter  int DEPTH = 2,
  localparam int CNT_W = $clog2(DEPTH + 1)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push_i,
  input  cdb_msg_t         push_msg_i,
  input  logic             pop_i,
  output cdb_msg_t         head_o,
  output logic [CNT_W-1:0] count_o
);

  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  cdb_msg_t         mem_q [DEPTH];
  logic [PTR_W-1:0] wr_q, rd_q;
  logic [CNT_W-1:0] count_q;
  logic             do_pop;

  function automatic logic [PTR_W-1:0] next_ptr(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(DEPTH - 1)) ? '0 : p + PTR_W'(1);
  endfunction

  assign do_pop  = pop_i && (count_q != '0);
  assign head_o  = mem_q[rd_q];
  assign count_o = count_q;

  // NOTE: storage has no reset; only pointers and count define which entries are live.
  always_ff @(posedge clk) begin
    if (push_i) mem_q[wr_q] <= push_msg_i;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_q    <= '0;
      rd_q    <= '0;
      count_q <= '0;
    end else begin
      if (push_i) wr_q <= next_ptr(wr_q);
      if (do_pop) rd_q <= next_ptr(rd_q);
      case ({push_i, do_pop})
        2'b10:   count_q <= count_q + CNT_W'(1);
        2'b01:   count_q <= count_q - CNT_W'(1);
        default: ;
      endcase
    end
  end

endmodule

// File: rtl/adder_cdb_writeback.sv
// Adder execution unit and CDB writeback. Accepts one ready RS entry per cycle,
// computes ADD/SUB, carries it through a fixed LATENCY-stage pipeline into a
// result FIFO, and broadcasts {tag,value,ovf} on the CDB under request/grant.
// Each broadcast also releases the RS entry (FreeValid/FreeTag).
// Ports:
//   Clock, Resetn                  clock, asynchronous active-low reset
//   DispValid/DispReady            dispatch handshake from the adder RS
//   DispTag/DispOp/DispVj/DispVk   dispatched entry
//   CdbReq/CdbGrant                bus request (buffer non-empty) and grant
//   CdbValid/CdbTag/CdbValue/CdbOvf  registered broadcast, one-cycle strobe
//   FreeValid/FreeTag              RS release, mirrors the broadcast
module adder_cdb_writeback
  import tomasulo_pkg::*;
#(
  parameter int LATENCY    = 2,
  parameter int OBUF_DEPTH = 2
) (
  input  logic              Clock,
  input  logic              Resetn,
  input  logic              DispValid,
  output logic              DispReady,
  input  logic [TAG_W-1:0]  DispTag,
  input  logic [3:0]        DispOp,
  input  logic [DATA_W-1:0] DispVj,
  input  logic [DATA_W-1:0] DispVk,
  output logic              CdbReq,
  input  logic              CdbGrant,
  output logic              CdbValid,
  output logic [TAG_W-1:0]  CdbTag,
  output logic [DATA_W-1:0] CdbValue,
  output logic              CdbOvf,
  output logic              FreeValid,
  output logic [TAG_W-1:0]  FreeTag
);

  localparam int CNT_W = $clog2(LATENCY + OBUF_DEPTH + 1);
  localparam int BUF_W = $clog2(OBUF_DEPTH + 1);

  logic [DATA_W:0]    sum, diff;
  cdb_msg_t           exec_msg;
  logic [LATENCY-1:0] valid_q;
  cdb_msg_t           msg_q [LATENCY];
  logic [CNT_W-1:0]   inflight;
  logic [BUF_W-1:0]   buf_count;
  cdb_msg_t           head_msg;
  logic               live_q;
  logic               accept, pop;
  logic               cdb_valid_q;
  cdb_msg_t           cdb_msg_q;

  // NOTE: every signal gets a value on every path, so no latch is inferred.
  always_comb begin
    sum           = {1'b0, DispVj} + {1'b0, DispVk};
    diff          = {1'b0, DispVj} - {1'b0, DispVk};
    exec_msg.tag  = DispTag;
    case (DispOp)
      OP_ADD: begin
        exec_msg.value = sum[DATA_W-1:0];
        exec_msg.ovf   = sum[DATA_W];
      end
      // Top bit of the widened difference is the borrow, i.e. Vj < Vk.
      OP_SUB: begin
        exec_msg.value = diff[DATA_W-1:0];
        exec_msg.ovf   = diff[DATA_W];
      end
      // Undefined op codes execute as ADD.
      default: begin
        exec_msg.value = sum[DATA_W-1:0];
        exec_msg.ovf   = sum[DATA_W];
      end
    endcase
  end

  always_comb begin
    inflight = '0;
    for (int i = 0; i < LATENCY; i++) inflight = inflight + CNT_W'(valid_q[i]);
  end

  // Credit: every in-flight op already owns a buffer slot, so the pipeline
  // exit can never find the buffer full. live_q holds ready low during reset.
  assign DispReady = live_q && ((inflight + CNT_W'(buf_count)) < CNT_W'(OBUF_DEPTH));
  assign accept    = DispValid && DispReady && (DispTag != TAG_NONE);
  assign CdbReq    = (buf_count != '0);
  assign pop       = CdbReq && CdbGrant;

  // NOTE: sequential state uses non-blocking assignment so all stages shift on the same edge.
  always_ff @(posedge Clock or negedge Resetn) begin
    if (!Resetn) begin
      live_q  <= 1'b0;
      valid_q <= '0;
    end else begin
      live_q     <= 1'b1;
      valid_q[0] <= accept;
      for (int i = 1; i < LATENCY; i++) valid_q[i] <= valid_q[i-1];
    end
  end

  always_ff @(posedge Clock) begin
    msg_q[0] <= exec_msg;
    for (int i = 1; i < LATENCY; i++) msg_q[i] <= msg_q[i-1];
  end

  result_fifo #(.DEPTH(OBUF_DEPTH)) u_obuf (
    .clk        (Clock),
    .rst_n      (Resetn),
    .push_i     (valid_q[LATENCY-1]),
    .push_msg_i (msg_q[LATENCY-1]),
    .pop_i      (pop),
    .head_o     (head_msg),
    .count_o    (buf_count)
  );

  // Broadcast register: strobe for one cycle per pop, payload holds afterwards.
  always_ff @(posedge Clock or negedge Resetn) begin
    if (!Resetn) begin
      cdb_valid_q <= 1'b0;
      cdb_msg_q   <= '0;
    end else begin
      cdb_valid_q <= pop;
      if (pop) cdb_msg_q <= head_msg;
    end
  end

  assign CdbValid  = cdb_valid_q;
  assign CdbTag    = cdb_msg_q.tag;
  assign CdbValue  = cdb_msg_q.value;
  assign CdbOvf    = cdb_msg_q.ovf;
  assign FreeValid = cdb_valid_q;
  assign FreeTag   = cdb_msg_q.tag;

endmodule

// File: tb/tb_adder_cdb_writeback.sv
// Self-checking bench for adder_cdb_writeback. A transaction-level model keeps
// outstanding results in a queue, each stamped with the first edge at which it
// may be granted; every cycle all DUT outputs are compared against it.
module tb_adder_cdb_writeback;
  import tomasulo_pkg::*;

  localparam int LATENCY    = 2;
  localparam int OBUF_DEPTH = 2;

  logic              Clock = 1'b0;
  logic              Resetn = 1'b0;
  logic              DispValid = 1'b0;
  logic              DispReady;
  logic [TAG_W-1:0]  DispTag = '0;
  logic [3:0]        DispOp = '0;
  logic [DATA_W-1:0] DispVj = '0;
  logic [DATA_W-1:0] DispVk = '0;
  logic              CdbReq;
  logic              CdbGrant = 1'b0;
  logic              CdbValid;
  logic [TAG_W-1:0]  CdbTag;
  logic [DATA_W-1:0] CdbValue;
  logic              CdbOvf;
  logic              FreeValid;
  logic [TAG_W-1:0]  FreeTag;

  adder_cdb_writeback #(.LATENCY(LATENCY), .OBUF_DEPTH(OBUF_DEPTH)) dut (
    .Clock     (Clock),
    .Resetn    (Resetn),
    .DispValid (DispValid),
    .DispReady (DispReady),
    .DispTag   (DispTag),
    .DispOp    (DispOp),
    .DispVj    (DispVj),
    .DispVk    (DispVk),
    .CdbReq    (CdbReq),
    .CdbGrant  (CdbGrant),
    .CdbValid  (CdbValid),
    .CdbTag    (CdbTag),
    .CdbValue  (CdbValue),
    .CdbOvf    (CdbOvf),
    .FreeValid (FreeValid),
    .FreeTag   (FreeTag)
  );

  always #5 Clock = ~Clock;

  int checks = 0;
  int errors = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // ---------------- reference model ----------------
  typedef struct { cdb_msg_t msg; int avail; } ent_t;
  typedef struct { logic [TAG_W-1:0] tag; int at; } bc_t;

  ent_t     mq[$];
  bc_t      bc_log[$];
  cdb_msg_t m_last;
  bit       m_valid;
  bit       m_ready_en;
  int       edge_n = 0;
  bit       last_xfer;

  function automatic cdb_msg_t ref_exec(input logic [TAG_W-1:0] tag, input logic [3:0] op,
                                        input logic [DATA_W-1:0] vj, input logic [DATA_W-1:0] vk);
    int a = int'(vj);
    int b = int'(vk);
    int r;
    cdb_msg_t m;
    m.tag = tag;
    if (op == 4'd1) begin
      r     = a - b;
      m.ovf = (a < b);
      if (r < 0) r += (1 << DATA_W);
    end else begin
      r     = a + b;
      m.ovf = (r >= (1 << DATA_W));
      r     = r % (1 << DATA_W);
    end
    m.value = r[DATA_W-1:0];
    return m;
  endfunction

  function automatic bit exp_ready();
    return m_ready_en && (mq.size() < OBUF_DEPTH);
  endfunction

  function automatic bit exp_req();
    return (mq.size() > 0) && (mq[0].avail <= edge_n + 1);
  endfunction

  task automatic reset_model();
    mq.delete();
    m_last     = '0;
    m_valid    = 1'b0;
    m_ready_en = 1'b0;
  endtask

  task automatic compare_all();
    check("ready", DispReady, exp_ready());
    check("req", CdbReq, exp_req());
    check("cdb_valid", CdbValid, m_valid);
    check("free_valid", FreeValid, m_valid);
    check("cdb_tag", CdbTag, m_last.tag);
    check("cdb_value", CdbValue, m_last.value);
    if (m_valid) begin
      check("cdb_ovf", CdbOvf, m_last.ovf);
      check("free_tag", FreeTag, m_last.tag);
    end
    if (CdbValid) bc_log.push_back('{CdbTag, edge_n});
  endtask

  task automatic check_zero(input string pfx);
    check({pfx, "_ready"}, DispReady, 0);
    check({pfx, "_req"}, CdbReq, 0);
    check({pfx, "_valid"}, CdbValid, 0);
    check({pfx, "_free_valid"}, FreeValid, 0);
    check({pfx, "_ovf"}, CdbOvf, 0);
    check({pfx, "_tag"}, CdbTag, 0);
    check({pfx, "_value"}, CdbValue, 0);
    check({pfx, "_free_tag"}, FreeTag, 0);
  endtask

  // One clock: decide transfer/pop from pre-edge inputs, advance model, compare.
  task automatic cycle();
    bit acc, pop, xfer;
    xfer = Resetn && DispValid && exp_ready();
    acc  = xfer && (DispTag != '0);
    pop  = Resetn && CdbGrant && exp_req();
    @(posedge Clock);
    edge_n++;
    last_xfer = xfer;
    if (Resetn) begin
      m_valid = pop;
      if (pop) m_last = mq.pop_front().msg;
      if (acc) mq.push_back('{ref_exec(DispTag, DispOp, DispVj, DispVk), edge_n + LATENCY + 1});
      m_ready_en = 1'b1;
    end
    #1;
    compare_all();
  endtask

  task automatic dispatch(input logic [TAG_W-1:0] tag, input logic [3:0] op,
                          input logic [DATA_W-1:0] vj, input logic [DATA_W-1:0] vk,
                          output int acc_edge);
    DispValid = 1'b1;
    DispTag   = tag;
    DispOp    = op;
    DispVj    = vj;
    DispVk    = vk;
    acc_edge  = -1;
    for (int i = 0; i < 30 && acc_edge < 0; i++) begin
      cycle();
      if (last_xfer) acc_edge = edge_n;
    end
    DispValid = 1'b0;
    if (acc_edge < 0) check("dispatch_timeout", 0, 1);
  endtask

  task automatic expect_bcast(input logic [TAG_W-1:0] tag, input logic [DATA_W-1:0] val,
                              input logic ovf, input int acc_edge);
    int seen = -1;
    for (int i = 0; i < 20 && seen < 0; i++) begin
      cycle();
      if (CdbValid) seen = edge_n;
    end
    if (seen < 0) check("bcast_timeout", 0, 1);
    else begin
      check("bc_tag", CdbTag, tag);
      check("bc_value", CdbValue, val);
      check("bc_ovf", CdbOvf, ovf);
      check("bc_free_tag", FreeTag, tag);
      check("bc_free_valid", FreeValid, 1);
      if (acc_edge >= 0) check("bc_latency", seen - acc_edge, LATENCY + 1);
    end
  endtask

  initial begin
    int a, a1, a2, a3, n;

    // Power-up reset
    reset_model();
    #1;
    check_zero("por");
    repeat (2) @(posedge Clock);
    #1;
    check("por_ready_held", DispReady, 0);
    #2 Resetn = 1'b1;
    #1 compare_all();
    cycle();
    check("por_ready_after", DispReady, 1);

    // ADD with carry, grant always high
    CdbGrant = 1'b1;
    dispatch(8'd3, 4'b0000, 8'hF0, 8'h20, a);
    expect_bcast(8'd3, 8'h10, 1'b1, a);

    // SUB with and without borrow
    dispatch(8'd5, 4'b0001, 8'h05, 8'h07, a);
    expect_bcast(8'd5, 8'hFE, 1'b1, a);
    dispatch(8'd6, 4'b0001, 8'h09, 8'h04, a);
    expect_bcast(8'd6, 8'h05, 1'b0, a);

    // Credit exhaustion with grant held low
    CdbGrant = 1'b0;
    bc_log.delete();
    dispatch(8'd1, 4'b0000, 8'h11, 8'h22, a1);
    dispatch(8'd2, 4'b0001, 8'h40, 8'h10, a2);
    check("t4_b2b_accept", a2 - a1, 1);
    DispValid = 1'b1;
    DispTag   = 8'd3;
    DispOp    = 4'b0000;
    DispVj    = 8'h01;
    DispVk    = 8'h01;
    repeat (4) begin
      cycle();
      check("t4_ready_low", DispReady, 0);
    end
    CdbGrant = 1'b1;
    a3 = -1;
    for (int i = 0; i < 10 && a3 < 0; i++) begin
      cycle();
      if (last_xfer) a3 = edge_n;
    end
    DispValid = 1'b0;
    if (a3 < 0) check("t4_tag3_timeout", 0, 1);
    if (bc_log.size() < 2) check("t4_bcast_count", bc_log.size(), 2);
    else begin
      check("t4_first_tag", bc_log[0].tag, 1);
      check("t4_second_tag", bc_log[1].tag, 2);
      check("t4_consecutive", bc_log[1].at - bc_log[0].at, 1);
      check("t4_tag3_after_pop", a3 - bc_log[0].at, 1);
    end
    expect_bcast(8'd3, 8'h02, 1'b0, -1);

    // Tag 0 is dropped
    repeat (2) cycle();
    bc_log.delete();
    DispTag   = '0;
    DispValid = 1'b1;
    check("t5_ready", DispReady, 1);
    cycle();
    DispValid = 1'b0;
    repeat (6) cycle();
    check("t5_req", CdbReq, 0);
    check("t5_bcasts", bc_log.size(), 0);
    check("t5_ready_after", DispReady, 1);

    // Grant pulses with an empty buffer are ignored
    repeat (4) begin
      CdbGrant = ~CdbGrant;
      cycle();
    end
    check("t6_idle_grant", bc_log.size(), 0);

    // Random traffic: overlapping push/pop, order checked against the model
    n = 0;
    for (int i = 0; i < 600 && n < 20; i++) begin
      DispValid = ($urandom_range(0, 3) != 0);
      DispTag   = ($urandom_range(0, 7) == 0) ? '0 : TAG_W'($urandom_range(1, 255));
      DispOp    = ($urandom_range(0, 3) == 3) ? 4'($urandom_range(2, 15)) : 4'($urandom_range(0, 1));
      DispVj    = DATA_W'($urandom);
      DispVk    = DATA_W'($urandom);
      CdbGrant  = ($urandom_range(0, 3) != 0);
      cycle();
      if (last_xfer && DispTag != '0) n++;
    end
    check("rand_accepts", n, 20);
    DispValid = 1'b0;
    CdbGrant  = 1'b1;
    repeat (12) cycle();
    check("rand_drained", CdbReq, 0);

    // Reset with two results buffered
    CdbGrant = 1'b0;
    dispatch(8'd7, 4'b0000, 8'h01, 8'h02, a);
    dispatch(8'd8, 4'b0001, 8'h03, 8'h04, a);
    repeat (LATENCY + 1) cycle();
    check("t1_buffered_req", CdbReq, 1);
    check("t1_full_ready", DispReady, 0);
    #2 Resetn = 1'b0;
    reset_model();
    #1;
    check_zero("t1_rst");
    @(posedge Clock);
    #1;
    check("t1_ready_in_rst", DispReady, 0);
    check("t1_valid_in_rst", CdbValid, 0);
    #2 Resetn = 1'b1;
    #1 compare_all();
    CdbGrant = 1'b1;
    bc_log.delete();
    cycle();
    check("t1_ready_after", DispReady, 1);
    repeat (6) cycle();
    check("t1_no_bcast", bc_log.size(), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
